// File: rtl/id_stage_pkg.sv
// Shared types and encodings for the decode stage.
// Opcodes, ALU/MEM op codes, instruction fields and ID/EX bundle.
package id_stage_pkg;

  localparam int WordAddrW = 30;
  localparam int WordDataW = 32;
  localparam int RegAddrW  = 5;
  localparam int AluOpW    = 4;
  localparam int MemOpW    = 2;
  localparam int OpcodeW   = 6;
  localparam int ImmW      = 16;

  localparam int OpMsb  = 31;
  localparam int OpLsb  = 26;
  localparam int RaMsb  = 25;
  localparam int RaLsb  = 21;
  localparam int RbMsb  = 20;
  localparam int RbLsb  = 16;
  localparam int RcMsb  = 15;
  localparam int RcLsb  = 11;
  localparam int ImmMsb = 15;

  typedef logic [WordAddrW-1:0] word_addr_t;
  typedef logic [WordDataW-1:0] word_data_t;
  typedef logic [RegAddrW-1:0]  reg_addr_t;
  typedef logic [OpcodeW-1:0]   opcode_t;

  localparam opcode_t ISA_OP_ANDR  = 6'h00;
  localparam opcode_t ISA_OP_ANDI  = 6'h01;
  localparam opcode_t ISA_OP_ORR   = 6'h02;
  localparam opcode_t ISA_OP_ORI   = 6'h03;
  localparam opcode_t ISA_OP_XORR  = 6'h04;
  localparam opcode_t ISA_OP_XORI  = 6'h05;
  localparam opcode_t ISA_OP_ADDUR = 6'h08;
  localparam opcode_t ISA_OP_ADDUI = 6'h09;
  localparam opcode_t ISA_OP_SUBUR = 6'h0b;
  localparam opcode_t ISA_OP_BE    = 6'h10;
  localparam opcode_t ISA_OP_BNE   = 6'h11;
  localparam opcode_t ISA_OP_JMP   = 6'h14;
  localparam opcode_t ISA_OP_LDW   = 6'h16;
  localparam opcode_t ISA_OP_STW   = 6'h17;

  typedef enum logic [AluOpW-1:0] {
    ALU_OP_NOP  = 4'd0,
    ALU_OP_AND  = 4'd1,
    ALU_OP_OR   = 4'd2,
    ALU_OP_XOR  = 4'd3,
    ALU_OP_ADDS = 4'd4,
    ALU_OP_ADDU = 4'd5,
    ALU_OP_SUBS = 4'd6,
    ALU_OP_SUBU = 4'd7
  } alu_op_e;

  typedef enum logic [MemOpW-1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef struct packed {
    word_addr_t pc;
    logic       en;
    alu_op_e    alu_op;
    word_data_t alu_in_0;
    word_data_t alu_in_1;
    mem_op_e    mem_op;
    word_data_t mem_wr_data;
    reg_addr_t  dst_addr;
    logic       gpr_we_;
    logic       illegal;
  } id_ex_t;

  localparam id_ex_t ID_EX_NOP = '{
    pc:          '0,
    en:          1'b0,
    alu_op:      ALU_OP_NOP,
    alu_in_0:    '0,
    alu_in_1:    '0,
    mem_op:      MEM_OP_NONE,
    mem_wr_data: '0,
    dst_addr:    '0,
    gpr_we_:     1'b1,
    illegal:     1'b0
  };

  function automatic word_data_t sext16(input logic [ImmW-1:0] imm);
    return {{(WordDataW-ImmW){imm[ImmW-1]}}, imm};
  endfunction

  function automatic word_data_t zext16(input logic [ImmW-1:0] imm);
    return {{(WordDataW-ImmW){1'b0}}, imm};
  endfunction

  // Youngest producer wins: EX result, then MEM result, then GPR file.
  function automatic word_data_t fwd_sel(
    input reg_addr_t  addr,
    input word_data_t gpr,
    input logic       ex_hit_en,
    input reg_addr_t  ex_dst,
    input word_data_t ex_data,
    input logic       mem_hit_en,
    input reg_addr_t  mem_dst,
    input word_data_t mem_data
  );
    if (ex_hit_en && ex_dst == addr) return ex_data;
    if (mem_hit_en && mem_dst == addr) return mem_data;
    return gpr;
  endfunction

endpackage

// File: rtl/id_stage_decoder.sv
// Combinational decode, operand bypass and branch resolution.
// Produces a candidate ID/EX bundle plus the raw branch decision.
module id_stage_decoder
  import id_stage_pkg::*;
(
  input  logic [WordAddrW-1:0] if_pc_i,
  input  logic [WordDataW-1:0] if_insn_i,
  input  logic                 if_en_i,
  input  logic [WordDataW-1:0] gpr_rd_data_0_i,
  input  logic [WordDataW-1:0] gpr_rd_data_1_i,
  input  logic [WordDataW-1:0] ex_fwd_data_i,
  input  logic [RegAddrW-1:0]  ex_dst_addr_i,
  input  logic                 ex_gpr_we_n_i,
  input  logic                 ex_en_i,
  input  logic [WordDataW-1:0] mem_fwd_data_i,
  input  logic [RegAddrW-1:0]  mem_dst_addr_i,
  input  logic                 mem_gpr_we_n_i,
  input  logic                 mem_en_i,
  output id_ex_t               dec_o,
  output logic                 uses_rb_o,
  output logic                 taken_o,
  output logic [WordAddrW-1:0] br_addr_o
);

  opcode_t          op;
  reg_addr_t        ra;
  reg_addr_t        rb;
  reg_addr_t        rc;
  logic [ImmW-1:0]  imm;
  word_data_t       ra_d;
  word_data_t       rb_d;
  word_data_t       imm_s;
  word_data_t       imm_z;
  word_addr_t       br_tgt;
  logic             ex_hit;
  logic             mem_hit;
  logic             rr_form;
  logic             wr_rb;

  assign op  = if_insn_i[OpMsb:OpLsb];
  assign ra  = if_insn_i[RaMsb:RaLsb];
  assign rb  = if_insn_i[RbMsb:RbLsb];
  assign rc  = if_insn_i[RcMsb:RcLsb];
  assign imm = if_insn_i[ImmMsb:0];

  assign ex_hit  = ex_en_i & ~ex_gpr_we_n_i;
  assign mem_hit = mem_en_i & ~mem_gpr_we_n_i;

  assign ra_d = fwd_sel(ra, gpr_rd_data_0_i,
                        ex_hit, ex_dst_addr_i, ex_fwd_data_i,
                        mem_hit, mem_dst_addr_i, mem_fwd_data_i);
  assign rb_d = fwd_sel(rb, gpr_rd_data_1_i,
                        ex_hit, ex_dst_addr_i, ex_fwd_data_i,
                        mem_hit, mem_dst_addr_i, mem_fwd_data_i);

  assign imm_s  = sext16(imm);
  assign imm_z  = zext16(imm);
  assign br_tgt = if_pc_i + 30'd1 + imm_s[WordAddrW-1:0];

  // Opcode decode into the ID/EX bundle and branch decision.
  always_comb begin
    dec_o             = ID_EX_NOP;
    dec_o.pc          = if_pc_i;
    dec_o.en          = if_en_i;
    dec_o.alu_in_0    = ra_d;
    dec_o.alu_in_1    = rb_d;
    dec_o.mem_wr_data = rb_d;
    dec_o.dst_addr    = rb;
    uses_rb_o         = 1'b0;
    taken_o           = 1'b0;
    br_addr_o         = br_tgt;
    rr_form           = 1'b0;
    wr_rb             = 1'b0;
    unique case (1'b1)
      op == ISA_OP_ANDR: begin
        dec_o.alu_op = ALU_OP_AND;
        rr_form      = 1'b1;
      end
      op == ISA_OP_ORR: begin
        dec_o.alu_op = ALU_OP_OR;
        rr_form      = 1'b1;
      end
      op == ISA_OP_XORR: begin
        dec_o.alu_op = ALU_OP_XOR;
        rr_form      = 1'b1;
      end
      op == ISA_OP_ADDUR: begin
        dec_o.alu_op = ALU_OP_ADDU;
        rr_form      = 1'b1;
      end
      op == ISA_OP_SUBUR: begin
        dec_o.alu_op = ALU_OP_SUBU;
        rr_form      = 1'b1;
      end
      op == ISA_OP_ANDI: begin
        dec_o.alu_op   = ALU_OP_AND;
        dec_o.alu_in_1 = imm_z;
        wr_rb          = 1'b1;
      end
      op == ISA_OP_ORI: begin
        dec_o.alu_op   = ALU_OP_OR;
        dec_o.alu_in_1 = imm_z;
        wr_rb          = 1'b1;
      end
      op == ISA_OP_XORI: begin
        dec_o.alu_op   = ALU_OP_XOR;
        dec_o.alu_in_1 = imm_z;
        wr_rb          = 1'b1;
      end
      op == ISA_OP_ADDUI: begin
        dec_o.alu_op   = ALU_OP_ADDU;
        dec_o.alu_in_1 = imm_s;
        wr_rb          = 1'b1;
      end
      op == ISA_OP_LDW: begin
        dec_o.alu_op   = ALU_OP_ADDU;
        dec_o.alu_in_1 = imm_s;
        dec_o.mem_op   = MEM_OP_LOAD;
        wr_rb          = 1'b1;
      end
      op == ISA_OP_STW: begin
        dec_o.alu_op   = ALU_OP_ADDU;
        dec_o.alu_in_1 = imm_s;
        dec_o.mem_op   = MEM_OP_STORE;
        uses_rb_o      = 1'b1;
      end
      op == ISA_OP_BE: begin
        uses_rb_o = 1'b1;
        taken_o   = (ra_d == rb_d);
      end
      op == ISA_OP_BNE: begin
        uses_rb_o = 1'b1;
        taken_o   = (ra_d != rb_d);
      end
      op == ISA_OP_JMP: begin
        taken_o   = 1'b1;
        br_addr_o = ra_d[WordDataW-1:2];
      end
      default: begin
        dec_o.illegal = 1'b1;
      end
    endcase
    if (rr_form) begin
      dec_o.dst_addr = rc;
      dec_o.gpr_we_  = 1'b0;
      uses_rb_o      = 1'b1;
    end
    if (wr_rb) begin
      dec_o.gpr_we_ = 1'b0;
    end
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode pipeline stage.
// Wraps the decoder, load-use detection and the ID/EX register.
module id_stage
  import id_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WordAddrW-1:0] if_pc,
  input  logic [WordDataW-1:0] if_insn,
  input  logic                 if_en,
  output logic [RegAddrW-1:0]  gpr_rd_addr_0,
  output logic [RegAddrW-1:0]  gpr_rd_addr_1,
  input  logic [WordDataW-1:0] gpr_rd_data_0,
  input  logic [WordDataW-1:0] gpr_rd_data_1,
  input  logic [WordDataW-1:0] ex_fwd_data,
  input  logic [RegAddrW-1:0]  ex_dst_addr,
  input  logic                 ex_gpr_we_,
  input  logic                 ex_en,
  input  logic [WordDataW-1:0] mem_fwd_data,
  input  logic [RegAddrW-1:0]  mem_dst_addr,
  input  logic                 mem_gpr_we_,
  input  logic                 mem_en,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 br_taken,
  output logic [WordAddrW-1:0] br_addr,
  output logic                 ld_hazard,
  output logic [WordAddrW-1:0] id_pc,
  output logic                 id_en,
  output logic [AluOpW-1:0]    id_alu_op,
  output logic [WordDataW-1:0] id_alu_in_0,
  output logic [WordDataW-1:0] id_alu_in_1,
  output logic [MemOpW-1:0]    id_mem_op,
  output logic [WordDataW-1:0] id_mem_wr_data,
  output logic [RegAddrW-1:0]  id_dst_addr,
  output logic                 id_gpr_we_,
  output logic                 id_illegal
);

  id_ex_t    dec;
  id_ex_t    id_d;
  id_ex_t    id_q;
  logic      uses_rb;
  logic      dec_taken;
  reg_addr_t ra;
  reg_addr_t rb;

  assign ra            = if_insn[RaMsb:RaLsb];
  assign rb            = if_insn[RbMsb:RbLsb];
  assign gpr_rd_addr_0 = ra;
  assign gpr_rd_addr_1 = rb;

  id_stage_decoder u_dec (
    .if_pc_i         (if_pc),
    .if_insn_i       (if_insn),
    .if_en_i         (if_en),
    .gpr_rd_data_0_i (gpr_rd_data_0),
    .gpr_rd_data_1_i (gpr_rd_data_1),
    .ex_fwd_data_i   (ex_fwd_data),
    .ex_dst_addr_i   (ex_dst_addr),
    .ex_gpr_we_n_i   (ex_gpr_we_),
    .ex_en_i         (ex_en),
    .mem_fwd_data_i  (mem_fwd_data),
    .mem_dst_addr_i  (mem_dst_addr),
    .mem_gpr_we_n_i  (mem_gpr_we_),
    .mem_en_i        (mem_en),
    .dec_o           (dec),
    .uses_rb_o       (uses_rb),
    .taken_o         (dec_taken),
    .br_addr_o       (br_addr)
  );

  assign ld_hazard = if_en & id_q.en
                   & (id_q.mem_op == MEM_OP_LOAD)
                   & ((id_q.dst_addr == ra)
                     | (uses_rb & (id_q.dst_addr == rb)));

  // A redirect only counts when this slot actually advances.
  assign br_taken = dec_taken & if_en & ~ld_hazard
                  & ~stall & ~flush & reset;

  // Next ID/EX value: hold on stall, bubble on flush/hazard/empty slot.
  always_comb begin
    id_d = id_q;
    if (stall) begin
      id_d = id_q;
    end else if (flush || ld_hazard || !if_en) begin
      id_d = ID_EX_NOP;
    end else begin
      id_d = dec;
    end
  end

  // ID/EX register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_q <= ID_EX_NOP;
    end else begin
      id_q <= id_d;
    end
  end

  assign id_pc          = id_q.pc;
  assign id_en          = id_q.en;
  assign id_alu_op      = id_q.alu_op;
  assign id_alu_in_0    = id_q.alu_in_0;
  assign id_alu_in_1    = id_q.alu_in_1;
  assign id_mem_op      = id_q.mem_op;
  assign id_mem_wr_data = id_q.mem_wr_data;
  assign id_dst_addr    = id_q.dst_addr;
  assign id_gpr_we_     = id_q.gpr_we_;
  assign id_illegal     = id_q.illegal;

endmodule
